// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: scanning driver for a 4-digit common-anode seven-segment
// display. A 16-bit hex value plus four decimal-point flags are accepted
// through a ready/load handshake into a shadow register. The shadow value is
// copied to the displayed copy only at a frame boundary, so a frame never
// shows a mix of old and new digits. Every slot starts with a blanking
// window with all anodes off.
//
// Optional build macro: SEG7_ZERO_BLANK_EN enables leading-zero suppression.
// Digit k (3..1) is blanked when nibbles k..3 are all zero and its decimal
// point is off. Digit 0 is never blanked. The anode is still strobed for a
// suppressed digit.

module seg7_scan_mux #(
  parameter int unsigned REFRESH_DIV  = 12500,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam logic [15:0] DIV_LAST  = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] BLANK_LIM = 16'(BLANK_CYCLES);

  // Hex digit to active-low gfedcba pattern.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

`ifdef SEG7_ZERO_BLANK_EN
  // True when digit k is a leading zero without a decimal point.
  function automatic logic leading_zero(input logic [15:0] val,
                                        input logic [3:0]  dpv,
                                        input logic [1:0]  k);
    logic z;
    case (k)
      2'd3:    z = (val[15:12] == 4'h0) && !dpv[3];
      2'd2:    z = (val[15:8] == 8'h00) && !dpv[2];
      2'd1:    z = (val[15:4] == 12'h000) && !dpv[1];
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  logic [15:0] disp_val_r;
  logic [3:0]  disp_dp_r;
  logic [15:0] pend_val_r;
  logic [3:0]  pend_dp_r;
  logic        pending_r;
  logic [15:0] div_cnt_r;
  logic [1:0]  dig_idx_r;
  logic        ready_r;
  logic [6:0]  seg_r;
  logic        dp_r;
  logic [3:0]  an_r;

  logic        slot_end_s;
  logic        frame_end_s;
  logic        commit_s;
  logic        accept_s;
  logic        pending_nxt_s;
  logic [15:0] div_nxt_s;
  logic [1:0]  idx_nxt_s;
  logic [15:0] disp_val_nxt_s;
  logic [3:0]  disp_dp_nxt_s;
  logic [3:0]  nib_s;
  logic        zero_blank_s;
  logic [6:0]  seg_nxt_s;
  logic        dp_nxt_s;
  logic [3:0]  an_nxt_s;

  assign slot_end_s  = (div_cnt_r == DIV_LAST);
  assign frame_end_s = slot_end_s && (dig_idx_r == 2'd3);
  // Commit looks at the flag from before this cycle, so a load accepted on
  // the boundary itself waits for the following frame.
  assign commit_s    = frame_end_s && pending_r;
  assign accept_s    = load && !pending_r;

  // Pending flag next state: set on accept, cleared on commit (never both).
  always_comb begin
    pending_nxt_s = pending_r;
    if (commit_s) begin
      pending_nxt_s = 1'b0;
    end else if (accept_s) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Scan counter next state: prescaler wrap advances the digit index.
  always_comb begin
    div_nxt_s = div_cnt_r;
    idx_nxt_s = dig_idx_r;
    if (slot_end_s) begin
      div_nxt_s = 16'd0;
      idx_nxt_s = dig_idx_r + 2'd1;
    end else begin
      div_nxt_s = div_cnt_r + 16'd1;
      idx_nxt_s = dig_idx_r;
    end
  end

  // Displayed value next state, so the output stage sees a commit at once.
  always_comb begin
    disp_val_nxt_s = disp_val_r;
    disp_dp_nxt_s  = disp_dp_r;
    if (commit_s) begin
      disp_val_nxt_s = pend_val_r;
      disp_dp_nxt_s  = pend_dp_r;
    end else begin
      disp_val_nxt_s = disp_val_r;
      disp_dp_nxt_s  = disp_dp_r;
    end
  end

  // Select the nibble of the digit that will be shown next cycle.
  always_comb begin
    nib_s = 4'h0;
    case (idx_nxt_s)
      2'd0:    nib_s = disp_val_nxt_s[3:0];
      2'd1:    nib_s = disp_val_nxt_s[7:4];
      2'd2:    nib_s = disp_val_nxt_s[11:8];
      2'd3:    nib_s = disp_val_nxt_s[15:12];
      default: nib_s = 4'h0;
    endcase
  end

`ifdef SEG7_ZERO_BLANK_EN
  assign zero_blank_s = leading_zero(disp_val_nxt_s, disp_dp_nxt_s, idx_nxt_s);
`else
  assign zero_blank_s = 1'b0;
`endif

  // Pin values for next cycle: blanking window, else one anode plus pattern.
  always_comb begin
    an_nxt_s  = 4'b1111;
    seg_nxt_s = 7'h7F;
    dp_nxt_s  = 1'b1;
    if (div_nxt_s < BLANK_LIM) begin
      an_nxt_s  = 4'b1111;
      seg_nxt_s = 7'h7F;
      dp_nxt_s  = 1'b1;
    end else begin
      case (idx_nxt_s)
        2'd0:    an_nxt_s = 4'b1110;
        2'd1:    an_nxt_s = 4'b1101;
        2'd2:    an_nxt_s = 4'b1011;
        2'd3:    an_nxt_s = 4'b0111;
        default: an_nxt_s = 4'b1111;
      endcase
      if (zero_blank_s) begin
        seg_nxt_s = 7'h7F;
      end else begin
        seg_nxt_s = hex_decode(nib_s);
      end
      dp_nxt_s = ~disp_dp_nxt_s[idx_nxt_s];
    end
  end

  // Shadow register capture on an accepted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_r <= 16'h0000;
      pend_dp_r  <= 4'h0;
    end else if (accept_s) begin
      pend_val_r <= value_in;
      pend_dp_r  <= dp_in;
    end
  end

  // Pending flag and the ready strobe derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      pending_r <= pending_nxt_s;
      ready_r   <= !pending_nxt_s;
    end
  end

  // Displayed copy, updated only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val_r <= 16'h0000;
      disp_dp_r  <= 4'h0;
    end else begin
      disp_val_r <= disp_val_nxt_s;
      disp_dp_r  <= disp_dp_nxt_s;
    end
  end

  // Refresh prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= 16'd0;
      dig_idx_r <= 2'd0;
    end else begin
      div_cnt_r <= div_nxt_s;
      dig_idx_r <= idx_nxt_s;
    end
  end

  // Registered display pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= 4'b1111;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
    end
  end

  assign ready = ready_r;
  assign seg   = seg_r;
  assign dp    = dp_r;
  assign an    = an_r;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with REFRESH_DIV=8, BLANK_CYCLES=2. A reference
// model tracks the frame position (0..31 cycles since reset release) and the
// displayed/shadow values; every cycle's pins are compared against it, plus
// directed checks against fixed expected patterns.

module tb_seg7_scan_mux;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_checks = 0;
  int n_pass   = 0;

  int          m_cnt;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_pend;
  logic [15:0] m_pval;
  logic [3:0]  m_pdp;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_in(value_in),
    .dp_in   (dp_in),
    .load    (load),
    .ready   (ready),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_val  = 16'h0000;
    m_dp   = 4'h0;
    m_pend = 1'b0;
    m_pval = 16'h0000;
    m_pdp  = 4'h0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge();
    logic was_pend;
    was_pend = m_pend;
    if (m_cnt == FRAME - 1 && was_pend) begin
      m_val  = m_pval;
      m_dp   = m_pdp;
      m_pend = 1'b0;
    end
    if (load && !was_pend) begin
      m_pval = value_in;
      m_pdp  = dp_in;
      m_pend = 1'b1;
    end
    m_cnt = (m_cnt + 1) % FRAME;
  endtask

  task automatic check_outputs();
    int          dig;
    int          pos;
    logic [3:0]  one;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [15:0] upper;
    pos = m_cnt % RD;
    dig = m_cnt / RD;
    one = 4'b0001;
    if (pos < BC) begin
      e_an  = 4'b1111;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = ~(one << dig);
      e_seg = SEG_TAB[(m_val >> (4 * dig)) & 16'h000F];
      e_dp  = ~m_dp[dig];
`ifdef SEG7_ZERO_BLANK_EN
      upper = m_val >> (4 * dig);
      if (dig != 0 && upper == 16'h0000 && !m_dp[dig]) e_seg = 7'h7F;
`else
      upper = 16'h0000;
`endif
    end
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("ready", 16'(ready), 16'(!m_pend));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 2 * FRAME && m_cnt != target; i++) cyc();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    cyc();
    load     = 1'b0;
  endtask

  task automatic wait_commit(input string tag);
    run_until(FRAME - 1);
    cyc();
    chk({tag, "_ready"}, 16'(ready), 16'd1);
  endtask

  task automatic slot_chk(input string tag, input int target, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
    run_until(target);
    chk({tag, "_an"}, 16'(an), 16'(e_an));
    chk({tag, "_seg"}, 16'(seg), 16'(e_seg));
    chk({tag, "_dp"}, 16'(dp), 16'(e_dp));
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_an", 16'(an), 16'h000F);
    chk("rst_seg", 16'(seg), 16'h007F);
    chk("rst_dp", 16'(dp), 16'd1);
    chk("rst_ready", 16'(ready), 16'd1);
    rst_n = 1'b1;
    check_outputs();
    cyc();
    cyc();
    chk("first_lit_an", 16'(an), 16'h000E);
    chk("first_lit_seg", 16'(seg), 16'h0040);

    // Basic load and frame-boundary commit.
    do_load(16'h12AF, 4'b0100);
    chk("load_ready_low", 16'(ready), 16'd0);
    wait_commit("c12af");
    slot_chk("c12af_d0", 2, 4'hE, 7'h0E, 1'b1);
    slot_chk("c12af_d1", 10, 4'hD, 7'h08, 1'b1);
    slot_chk("c12af_d2", 18, 4'hB, 7'h24, 1'b0);
    slot_chk("c12af_d3", 26, 4'h7, 7'h79, 1'b1);

    // Load exactly on the frame boundary: held for one more frame.
    run_until(FRAME - 1);
    value_in = 16'h3456;
    dp_in    = 4'h0;
    load     = 1'b1;
    cyc();
    load     = 1'b0;
    chk("bnd_ready_low", 16'(ready), 16'd0);
    slot_chk("bnd_old", 2, 4'hE, 7'h0E, 1'b1);
    wait_commit("bnd");
    slot_chk("bnd_new", 2, 4'hE, 7'h02, 1'b1);

    // Second load while not ready is ignored.
    do_load(16'h5981, 4'h0);
    do_load(16'hFFFF, 4'hF);
    wait_commit("ign");
    slot_chk("ign_d0", 2, 4'hE, 7'h79, 1'b1);
    slot_chk("ign_d3", 26, 4'h7, 7'h12, 1'b1);

    // Randomized loads, including many while not ready.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        value_in = 16'($urandom);
        dp_in    = 4'($urandom);
        load     = 1'b1;
      end else begin
        load     = 1'b0;
      end
      cyc();
    end
    load = 1'b0;

    // Reset with an update pending discards it.
    run_until(0);
    if (m_pend) wait_commit("pre_rst");
    run_until(0);
    do_load(16'($urandom) | 16'h1111, 4'($urandom));
    repeat ($urandom_range(1, 20)) cyc();
    chk("pend_before_rst", 16'(ready), 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 16'(an), 16'h000F);
    chk("arst_seg", 16'(seg), 16'h007F);
    chk("arst_dp", 16'(dp), 16'd1);
    chk("arst_ready", 16'(ready), 16'd1);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_outputs();
    slot_chk("post_rst_d0", 2, 4'hE, 7'h40, 1'b1);
    run_until(FRAME - 1);
    cyc();
    slot_chk("post_rst_frame2", 2, 4'hE, 7'h40, 1'b1);

`ifdef SEG7_ZERO_BLANK_EN
    do_load(16'h0007, 4'b0000);
    wait_commit("zb");
    slot_chk("zb_d0", 2, 4'hE, 7'h78, 1'b1);
    slot_chk("zb_d1", 10, 4'hD, 7'h7F, 1'b1);
    slot_chk("zb_d2", 18, 4'hB, 7'h7F, 1'b1);
    slot_chk("zb_d3", 26, 4'h7, 7'h7F, 1'b1);
    do_load(16'h0007, 4'b0010);
    wait_commit("zbdp");
    slot_chk("zbdp_d1", 10, 4'hD, 7'h40, 1'b0);
    slot_chk("zbdp_d2", 18, 4'hB, 7'h7F, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
